// File: rtl/ncc_sequencer.sv
// NCC grid sequencer: loads 64 descriptor words into the 16x16 PE grid,
// then streams one window of pixels through it, driving the shared
// window/accumulator load strobes and flagging valid column sums.
module ncc_sequencer #(
    parameter int ROWS       = 16,
    parameter int COL_GROUPS = 4,
    parameter int COLS       = 16,
    parameter int WIN_PIXELS = 640
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              desc_valid,
    output logic                              desc_ready,
    output logic                              desc_load_en,
    output logic [$clog2(ROWS)-1:0]           desc_row_sel,
    output logic [$clog2(COL_GROUPS)-1:0]     desc_col_sel,
    input  logic                              win_valid,
    output logic                              win_ready,
    output logic                              load_win_reg,
    output logic                              load_acc_sum_reg,
    output logic [$clog2(WIN_PIXELS+1)-1:0]   win_count,
    output logic                              result_valid,
    output logic                              busy,
    output logic                              done
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COL_GROUPS);
    localparam int WW = $clog2(WIN_PIXELS + 1);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL_GROUPS - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_PIXELS - 1);
    localparam logic [WW-1:0] SUM_MIN  = WW'(COLS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DESC_LOAD  = 2'd1,
        WIN_STREAM = 2'd2,
        DONE_ST    = 2'd3
    } state_t;

    state_t        state;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [WW-1:0] win_cnt;
    logic          sum_valid;
    logic [WW-1:0] win_next;

    // Abort kills any handshake in its own cycle, so readiness is gated by it.
    assign desc_ready       = (state == DESC_LOAD) & ~abort;
    assign win_ready        = (state == WIN_STREAM) & ~abort;
    assign desc_load_en     = desc_valid & desc_ready;
    assign load_win_reg     = win_valid & win_ready;
    assign load_acc_sum_reg = win_valid & win_ready;
    assign desc_row_sel     = row_cnt;
    assign desc_col_sel     = col_cnt;
    assign win_count        = win_cnt;
    assign result_valid     = sum_valid;
    assign busy             = (state != IDLE);
    assign done             = (state == DONE_ST) & ~abort;
    assign win_next         = win_cnt + WW'(1);

    // Pass FSM with descriptor/window counters and the registered sum flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            col_cnt   <= '0;
            win_cnt   <= '0;
            sum_valid <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            row_cnt   <= '0;
            col_cnt   <= '0;
            win_cnt   <= '0;
            sum_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sum_valid <= 1'b0;
                    if (start) begin
                        state   <= DESC_LOAD;
                        row_cnt <= '0;
                        col_cnt <= '0;
                        win_cnt <= '0;
                    end
                end
                DESC_LOAD: begin
                    sum_valid <= 1'b0;
                    if (desc_valid) begin
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            if (row_cnt == ROW_LAST) begin
                                // 64th word: counters land back at (0,0)
                                row_cnt <= '0;
                                state   <= WIN_STREAM;
                            end else begin
                                row_cnt <= row_cnt + RW'(1);
                            end
                        end else begin
                            col_cnt <= col_cnt + CW'(1);
                        end
                    end
                end
                WIN_STREAM: begin
                    if (win_valid) begin
                        win_cnt   <= win_next;
                        // Column sums are meaningful once the chain has filled
                        sum_valid <= (win_next >= SUM_MIN);
                        if (win_cnt == WIN_LAST)
                            state <= DONE_ST;
                    end else begin
                        sum_valid <= 1'b0;
                    end
                end
                DONE_ST: begin
                    sum_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    sum_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
